// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell processes WIDTH-bit operands LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds the registered signed-overflow output ovf.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry_q;
  logic [CW-1:0]    count;
  logic             fa_s, fa_c;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only change on an accepted start or while shifting, so they hold through DONE/IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            sum     <= '0;
            count   <= '0;
          end
        end
        SHIFT: begin
          sum     <= {fa_s, sum[WIDTH-1:1]};
          carry_q <= fa_c;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          count   <= count + CW'(1);
          if (last_bit) begin
            cout <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
            ovf  <= carry_q ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an arithmetic reference model queues expected results
// on each accepted start; a negedge monitor checks busy every cycle and results on each done.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               done_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc        = 0;
  int   next_free  = 0;
  int   op_start   = -1;
  int   reset_cyc  = -1;

  // Reference model: an op accepted at edge k finishes with done after edge k+WIDTH, next accept at k+WIDTH+2.
  always @(posedge clk) begin
    logic [WIDTH:0] total;
    exp_t           e;
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
      op_start  = -1;
      next_free = cyc + 1;
      reset_cyc = cyc;
    end else if (start && cyc >= next_free) begin
      total      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      e.sum      = total[WIDTH-1:0];
      e.cout     = total[WIDTH];
      e.ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (total[WIDTH-1] != a[WIDTH-1]);
      e.done_cyc = cyc + WIDTH;
      q.push_back(e);
      op_start  = cyc;
      next_free = cyc + WIDTH + 2;
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (cyc > 0) begin
      exp_busy = (op_start >= 0) && (cyc >= op_start) && (cyc < op_start + WIDTH);
      checkOutput("busy", {{WIDTH{1'b0}}, busy}, {{WIDTH{1'b0}}, exp_busy});
      if (reset_cyc == cyc) begin
        checkOutput("reset_sum", {1'b0, sum}, '0);
        checkOutput("reset_cout", {{WIDTH{1'b0}}, cout}, '0);
        checkOutput("reset_done", {{WIDTH{1'b0}}, done}, '0);
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("reset_ovf", {{WIDTH{1'b0}}, ovf}, '0);
`endif
      end else if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          checkOutput("done_time", WIDTH'(cyc), WIDTH'(e.done_cyc));
          checkOutput("sum", {1'b0, sum}, {1'b0, e.sum});
          checkOutput("cout", {{WIDTH{1'b0}}, cout}, {{WIDTH{1'b0}}, e.cout});
`ifdef SERIAL_ADD_OVF_EN
          checkOutput("ovf", {{WIDTH{1'b0}}, ovf}, {{WIDTH{1'b0}}, e.ovf});
`endif
        end
      end else if (q.size() > 0 && q[0].done_cyc <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_done: got done=0 expected done=1 at cycle %0d", cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                               input logic c, input logic r);
    @(negedge clk);
    start = s;
    a     = aa;
    b     = bb;
    cin   = c;
    rst_n = r;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic runOp(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic c);
    applyStimulus(1'b1, aa, bb, c, 1'b1);
    idleCycles(WIDTH + 2);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    idleCycles(2);

    runOp(8'h35, 8'h4A, 1'b0);
    runOp(8'hFF, 8'h01, 1'b0);
    runOp(8'hFF, 8'hFF, 1'b1);

    // A start pulse while busy must be ignored.
    applyStimulus(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
    idleCycles(2);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    idleCycles(WIDTH + 2);

    // Reset lands on the 4th SHIFT edge.
    applyStimulus(1'b1, 8'hAA, 8'h55, 1'b0, 1'b1);
    idleCycles(3);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    idleCycles(2);
    runOp(8'h10, 8'h20, 1'b0);

    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
    idleCycles(WIDTH + 2);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 2) == 0, WIDTH'($urandom), WIDTH'($urandom),
                    1'($urandom), $urandom_range(0, 149) != 0);
    idleCycles(WIDTH + 4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_results: got %0d outstanding expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
